// File: rtl/conv_compute_sequencer.sv
// conv_compute_sequencer: issues cin/cout/col loop iterations per row and derives RAM addresses and strobes.
// Rev 1.0
`default_nettype none

module conv_compute_sequencer #(
    parameter int WIDTH_RAM_ADDR_SIZE      = 13,
    parameter int WIDTH_FEATURE_SIZE       = 12,
    parameter int WIDTH_TEMP_RAM_ADDR_SIZE = 7,
    parameter int WIDTH_CHANNEL_NUM_REG    = 10,
    parameter int DELAY_TIMES              = 23,
    parameter int ADDR_DELAY               = 2,
    parameter int WAIT_CYCLES              = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Start_Cu,
    input  logic                                Abort,
    input  logic                                compute_fifo_ready,
    input  logic                                M_ready,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0]    CIN_TIMES,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0]    COUT_TIMES,
    input  logic [WIDTH_FEATURE_SIZE-1:0]       COL_NUM,
    input  logic [WIDTH_FEATURE_SIZE-1:0]       ROW_NUM,
    output logic                                rd_en_fifo,
    output logic [WIDTH_RAM_ADDR_SIZE-1:0]      weight_addrb,
    output logic [WIDTH_TEMP_RAM_ADDR_SIZE-1:0] ram_temp_read_address,
    output logic [WIDTH_TEMP_RAM_ADDR_SIZE-1:0] ram_temp_write_address,
    output logic                                M_Valid,
    output logic                                First_Compute_Complete,
    output logic                                Row_Done,
    output logic                                Compute_Complete,
    output logic                                Busy,
    output logic [WIDTH_FEATURE_SIZE-1:0]       S_Count_Fifo,
    output logic [WIDTH_FEATURE_SIZE-1:0]       M_Count_Fifo
);

    localparam int CH    = WIDTH_CHANNEL_NUM_REG;
    localparam int FEAT  = WIDTH_FEATURE_SIZE;
    localparam int RAMW  = WIDTH_RAM_ADDR_SIZE;
    localparam int TEMPW = WIDTH_TEMP_RAM_ADDR_SIZE;
    localparam int PW    = CH + FEAT + RAMW;
    localparam int DLEN  = DELAY_TIMES + 1;
    localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT        = 3'd1,
        S_JUDGE_FIFO  = 3'd2,
        S_JUDGE_READY = 3'd3,
        S_COMPUTE     = 3'd4,
        S_JUDGE_ROW   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CH-1:0]     cin_num_q, cin_num_d, cout_num_q, cout_num_d;
    logic [FEAT-1:0]   col_num_q, col_num_d, row_num_q, row_num_d;
    logic [4:0]        wait_cnt_q, wait_cnt_d;
    logic [CH-1:0]     cin_cnt_q, cin_cnt_d, cout_cnt_q, cout_cnt_d;
    logic [FEAT-1:0]   col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [TEMPW-1:0]  wr_addr_q, wr_addr_d;
    logic              done_q, done_d;
    logic [FEAT-1:0]   count_fifo_q, count_fifo_d;
    logic [RAMW-1:0]   waddr_q [ADDR_DELAY+1];
    logic [RAMW-1:0]   waddr_s0_d;
    logic [TEMPW-1:0]  taddr_q [ADDR_DELAY+1];
    logic [TEMPW-1:0]  taddr_s0_d;
    logic [DLEN-1:0]   mv_q;
    logic [DLEN-1:0]   fcc_q;

    logic w_issue, w_cin_last, w_cout_last, w_col_last, w_row_last, w_zero_cfg;

    assign w_issue     = (state_q == S_COMPUTE) && M_ready && !Abort;
    assign w_cin_last  = (cin_cnt_q  == cin_num_q  - CH'(1));
    assign w_cout_last = (cout_cnt_q == cout_num_q - CH'(1));
    assign w_col_last  = (col_cnt_q  == col_num_q  - FEAT'(1));
    assign w_row_last  = (row_cnt_q  == row_num_q  - FEAT'(1));
    assign w_zero_cfg  = (cin_num_q == '0) || (cout_num_q == '0) ||
                         (col_num_q == '0) || (row_num_q == '0);

    always_comb begin
        state_d      = state_q;
        cin_num_d    = cin_num_q;
        cout_num_d   = cout_num_q;
        col_num_d    = col_num_q;
        row_num_d    = row_num_q;
        wait_cnt_d   = wait_cnt_q;
        cin_cnt_d    = cin_cnt_q;
        cout_cnt_d   = cout_cnt_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        done_d       = 1'b0;
        rd_en_d      = w_issue && (cout_cnt_q == '0);
        count_fifo_d = FEAT'(PW'(col_num_q) * PW'(cin_num_q));
        waddr_s0_d   = waddr_q[0];
        taddr_s0_d   = taddr_q[0];

        if (w_issue) begin
            waddr_s0_d = RAMW'(PW'(cout_cnt_q) * PW'(cin_num_q) + PW'(cin_cnt_q));
            taddr_s0_d = TEMPW'(cin_cnt_q);
        end

        // Clear takes priority so each column restarts its temp writes at 0.
        if (!rd_en_q || ((cin_cnt_q == '0) && (cout_cnt_q == '0)))
            wr_addr_d = '0;
        else
            wr_addr_d = wr_addr_q + TEMPW'(1);

        case (state_q)
            S_IDLE: begin
                if (Start_Cu) begin
                    cin_num_d  = CIN_TIMES;
                    cout_num_d = COUT_TIMES;
                    col_num_d  = COL_NUM;
                    row_num_d  = ROW_NUM;
                    wait_cnt_d = '0;
                    cin_cnt_d  = '0;
                    cout_cnt_d = '0;
                    col_cnt_d  = '0;
                    row_cnt_d  = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    if (w_zero_cfg) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_JUDGE_FIFO;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end
            end
            S_JUDGE_FIFO: begin
                if (compute_fifo_ready)
                    state_d = S_JUDGE_READY;
            end
            S_JUDGE_READY: begin
                if (M_ready)
                    state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (w_issue) begin
                    if (w_cin_last) begin
                        cin_cnt_d = '0;
                        if (w_cout_last) begin
                            cout_cnt_d = '0;
                            if (w_col_last) begin
                                col_cnt_d = '0;
                                state_d   = S_JUDGE_ROW;
                            end else begin
                                col_cnt_d = col_cnt_q + FEAT'(1);
                            end
                        end else begin
                            cout_cnt_d = cout_cnt_q + CH'(1);
                        end
                    end else begin
                        cin_cnt_d = cin_cnt_q + CH'(1);
                    end
                end
            end
            S_JUDGE_ROW: begin
                if (w_row_last) begin
                    row_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    row_cnt_d = row_cnt_q + FEAT'(1);
                    state_d   = S_JUDGE_FIFO;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (Abort) begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
            cin_cnt_d  = '0;
            cout_cnt_d = '0;
            col_cnt_d  = '0;
            row_cnt_d  = '0;
            done_d     = 1'b0;
            wr_addr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cin_num_q    <= '0;
            cout_num_q   <= '0;
            col_num_q    <= '0;
            row_num_q    <= '0;
            wait_cnt_q   <= '0;
            cin_cnt_q    <= '0;
            cout_cnt_q   <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            rd_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            done_q       <= 1'b0;
            count_fifo_q <= '0;
            mv_q         <= '0;
            fcc_q        <= '0;
            for (int i = 0; i <= ADDR_DELAY; i++) begin
                waddr_q[i] <= '0;
                taddr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cin_num_q    <= cin_num_d;
            cout_num_q   <= cout_num_d;
            col_num_q    <= col_num_d;
            row_num_q    <= row_num_d;
            wait_cnt_q   <= wait_cnt_d;
            cin_cnt_q    <= cin_cnt_d;
            cout_cnt_q   <= cout_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            rd_en_q      <= rd_en_d;
            wr_addr_q    <= wr_addr_d;
            done_q       <= done_d;
            count_fifo_q <= count_fifo_d;
            waddr_q[0]   <= waddr_s0_d;
            taddr_q[0]   <= taddr_s0_d;
            for (int i = 1; i <= ADDR_DELAY; i++) begin
                waddr_q[i] <= waddr_q[i-1];
                taddr_q[i] <= taddr_q[i-1];
            end
            // Strobe delay lines run freely so results drain through stalls and after the row.
            mv_q[0]  <= w_issue && w_cin_last;
            fcc_q[0] <= w_issue && (cin_cnt_q == '0);
            for (int i = 1; i < DLEN; i++) begin
                mv_q[i]  <= mv_q[i-1];
                fcc_q[i] <= fcc_q[i-1];
            end
        end
    end

    assign rd_en_fifo             = rd_en_q;
    assign weight_addrb           = waddr_q[ADDR_DELAY];
    assign ram_temp_read_address  = taddr_q[ADDR_DELAY];
    assign ram_temp_write_address = wr_addr_q;
    assign M_Valid                = mv_q[DELAY_TIMES];
    assign First_Compute_Complete = fcc_q[DELAY_TIMES-1];
    assign Row_Done               = (state_q == S_JUDGE_ROW);
    assign Compute_Complete       = done_q;
    assign Busy                   = (state_q != S_IDLE);
    assign S_Count_Fifo           = count_fifo_q;
    assign M_Count_Fifo           = count_fifo_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_compute_sequencer.sv
// tb_conv_compute_sequencer: directed checks of conv_compute_sequencer with default parameters.
// Rev 1.0
`default_nettype none

module tb_conv_compute_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start_Cu = 1'b0;
    logic        Abort = 1'b0;
    logic        compute_fifo_ready = 1'b0;
    logic        M_ready = 1'b0;
    logic [9:0]  CIN_TIMES = '0;
    logic [9:0]  COUT_TIMES = '0;
    logic [11:0] COL_NUM = '0;
    logic [11:0] ROW_NUM = '0;
    logic        rd_en_fifo;
    logic [12:0] weight_addrb;
    logic [6:0]  ram_temp_read_address;
    logic [6:0]  ram_temp_write_address;
    logic        M_Valid;
    logic        First_Compute_Complete;
    logic        Row_Done;
    logic        Compute_Complete;
    logic        Busy;
    logic [11:0] S_Count_Fifo;
    logic [11:0] M_Count_Fifo;

    conv_compute_sequencer dut (
        .clk                    (clk),
        .rst                    (rst),
        .Start_Cu               (Start_Cu),
        .Abort                  (Abort),
        .compute_fifo_ready     (compute_fifo_ready),
        .M_ready                (M_ready),
        .CIN_TIMES              (CIN_TIMES),
        .COUT_TIMES             (COUT_TIMES),
        .COL_NUM                (COL_NUM),
        .ROW_NUM                (ROW_NUM),
        .rd_en_fifo             (rd_en_fifo),
        .weight_addrb           (weight_addrb),
        .ram_temp_read_address  (ram_temp_read_address),
        .ram_temp_write_address (ram_temp_write_address),
        .M_Valid                (M_Valid),
        .First_Compute_Complete (First_Compute_Complete),
        .Row_Done               (Row_Done),
        .Compute_Complete       (Compute_Complete),
        .Busy                   (Busy),
        .S_Count_Fifo           (S_Count_Fifo),
        .M_Count_Fifo           (M_Count_Fifo)
    );

    always #5 clk = ~clk;

    int n_rd = 0, n_mv = 0, n_rowdone = 0, n_cc = 0, n_fcc = 0;
    always @(negedge clk) begin
        if (rd_en_fifo === 1'b1)             n_rd++;
        if (M_Valid === 1'b1)                n_mv++;
        if (Row_Done === 1'b1)               n_rowdone++;
        if (Compute_Complete === 1'b1)       n_cc++;
        if (First_Compute_Complete === 1'b1) n_fcc++;
    end

    int errors = 0;
    int checks = 0;
    int e = 0;
    int b_rd, b_mv, b_rowdone, b_cc, b_fcc;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic to(input int target);
        while (e < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rd = n_rd; b_mv = n_mv; b_rowdone = n_rowdone; b_cc = n_cc; b_fcc = n_fcc;
    endtask

    // Start pulse is sampled at edge 0; e counts edges after it.
    task automatic start_job(input int cin, input int cout, input int col, input int row);
        CIN_TIMES  = 10'(cin);
        COUT_TIMES = 10'(cout);
        COL_NUM    = 12'(col);
        ROW_NUM    = 12'(row);
        Start_Cu   = 1'b1;
        tick();
        Start_Cu   = 1'b0;
        e = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(Busy), 0);
        chk({tag, "_rd"},     32'(rd_en_fifo), 0);
        chk({tag, "_waddr"},  32'(weight_addrb), 0);
        chk({tag, "_traddr"}, 32'(ram_temp_read_address), 0);
        chk({tag, "_twaddr"}, 32'(ram_temp_write_address), 0);
        chk({tag, "_mv"},     32'(M_Valid), 0);
        chk({tag, "_fcc"},    32'(First_Compute_Complete), 0);
        chk({tag, "_rowd"},   32'(Row_Done), 0);
        chk({tag, "_cc"},     32'(Compute_Complete), 0);
        chk({tag, "_scnt"},   32'(S_Count_Fifo), 0);
        chk({tag, "_mcnt"},   32'(M_Count_Fifo), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Nominal: CIN=2 COUT=2 COL=3 ROW=2, fifo and downstream always ready
        compute_fifo_ready = 1'b1;
        M_ready = 1'b1;
        snap();
        start_job(2, 2, 3, 2);
        chk("nom_busy_start", 32'(Busy), 1);
        CIN_TIMES = 10'd5; COUT_TIMES = 10'd7; COL_NUM = 12'd9; ROW_NUM = 12'd1;
        to(1);
        chk("nom_scnt", 32'(S_Count_Fifo), 6);
        chk("nom_mcnt", 32'(M_Count_Fifo), 6);
        to(6);
        chk("nom_rd_before", 32'(rd_en_fifo), 0);
        to(7);
        chk("nom_rd_first", 32'(rd_en_fifo), 1);
        chk("nom_twaddr_e7", 32'(ram_temp_write_address), 0);
        to(8);
        chk("nom_twaddr_e8", 32'(ram_temp_write_address), 1);
        to(9);
        chk("nom_waddr_0", 32'(weight_addrb), 0);
        chk("nom_traddr_0", 32'(ram_temp_read_address), 0);
        chk("nom_rd_cout1", 32'(rd_en_fifo), 0);
        to(10);
        chk("nom_waddr_1", 32'(weight_addrb), 1);
        chk("nom_traddr_1", 32'(ram_temp_read_address), 1);
        to(11);
        chk("nom_waddr_2", 32'(weight_addrb), 2);
        chk("nom_traddr_2", 32'(ram_temp_read_address), 0);
        Start_Cu = 1'b1;
        to(12);
        Start_Cu = 1'b0;
        chk("nom_waddr_3", 32'(weight_addrb), 3);
        to(13);
        chk("nom_waddr_wrap", 32'(weight_addrb), 0);
        to(18);
        chk("nom_rowdone_1", 32'(Row_Done), 1);
        to(29);
        chk("nom_fcc_first", 32'(First_Compute_Complete), 1);
        to(30);
        chk("nom_mv_e30", 32'(M_Valid), 0);
        to(31);
        chk("nom_mv_first", 32'(M_Valid), 1);
        to(33);
        chk("nom_rowdone_2", 32'(Row_Done), 1);
        chk("nom_cc_early", 32'(Compute_Complete), 0);
        to(34);
        chk("nom_cc", 32'(Compute_Complete), 1);
        chk("nom_busy_end", 32'(Busy), 0);
        to(35);
        chk("nom_cc_once", 32'(Compute_Complete), 0);
        to(62);
        chk("nom_rd_total", 32'(n_rd - b_rd), 12);
        chk("nom_mv_total", 32'(n_mv - b_mv), 12);
        chk("nom_fcc_total", 32'(n_fcc - b_fcc), 12);
        chk("nom_rowdone_total", 32'(n_rowdone - b_rowdone), 2);
        chk("nom_cc_total", 32'(n_cc - b_cc), 1);
        chk("nom_scnt_hold", 32'(S_Count_Fifo), 6);

        // Stall: M_ready low for 5 cycles after the fifth issue
        snap();
        start_job(2, 2, 3, 1);
        to(11);
        M_ready = 1'b0;
        to(13);
        chk("stall_waddr_e13", 32'(weight_addrb), 0);
        to(16);
        chk("stall_waddr_hold", 32'(weight_addrb), 0);
        chk("stall_busy", 32'(Busy), 1);
        M_ready = 1'b1;
        to(19);
        chk("stall_waddr_resume", 32'(weight_addrb), 1);
        to(24);
        chk("stall_cc", 32'(Compute_Complete), 1);
        to(33);
        chk("stall_mv_e33", 32'(M_Valid), 1);
        to(35);
        chk("stall_mv_stretched", 32'(M_Valid), 0);
        to(40);
        chk("stall_mv_e40", 32'(M_Valid), 1);
        to(50);
        chk("stall_rd_total", 32'(n_rd - b_rd), 6);
        chk("stall_mv_total", 32'(n_mv - b_mv), 6);
        chk("stall_cc_total", 32'(n_cc - b_cc), 1);

        // Zero configuration: COL_NUM=0
        snap();
        start_job(2, 2, 0, 2);
        to(3);
        chk("zero_cc_early", 32'(Compute_Complete), 0);
        chk("zero_busy_wait", 32'(Busy), 1);
        to(4);
        chk("zero_cc", 32'(Compute_Complete), 1);
        chk("zero_busy_idle", 32'(Busy), 0);
        to(40);
        chk("zero_rd_none", 32'(n_rd - b_rd), 0);
        chk("zero_mv_none", 32'(n_mv - b_mv), 0);
        chk("zero_cc_total", 32'(n_cc - b_cc), 1);

        // fifo not ready at the row boundary
        snap();
        start_job(1, 1, 2, 2);
        to(6);
        compute_fifo_ready = 1'b0;
        to(12);
        chk("fifo_hold_busy", 32'(Busy), 1);
        chk("fifo_hold_rd", 32'(rd_en_fifo), 0);
        chk("fifo_hold_rd_count", 32'(n_rd - b_rd), 2);
        to(14);
        compute_fifo_ready = 1'b1;
        to(18);
        chk("fifo_rowdone_2", 32'(Row_Done), 1);
        to(19);
        chk("fifo_cc", 32'(Compute_Complete), 1);
        to(50);
        chk("fifo_rd_total", 32'(n_rd - b_rd), 4);
        chk("fifo_mv_total", 32'(n_mv - b_mv), 4);
        chk("fifo_cc_total", 32'(n_cc - b_cc), 1);

        // Abort in Compute; then Abort beats Start_Cu in Idle
        snap();
        start_job(2, 2, 3, 2);
        to(9);
        Abort = 1'b1;
        to(10);
        Abort = 1'b0;
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_rd", 32'(rd_en_fifo), 0);
        Abort = 1'b1;
        Start_Cu = 1'b1;
        to(11);
        Abort = 1'b0;
        Start_Cu = 1'b0;
        chk("abort_prio_busy", 32'(Busy), 0);
        to(34);
        b_mv = n_mv;
        to(64);
        chk("abort_mv_quiet", 32'(n_mv - b_mv), 0);
        chk("abort_no_cc", 32'(n_cc - b_cc), 0);

        // Reset mid-row, then a complete job
        snap();
        start_job(2, 2, 3, 2);
        to(11);
        rst = 1'b1;
        to(12);
        chk_all_zero("rst_mid");
        to(13);
        rst = 1'b0;
        to(45);
        chk("rst_mv_quiet", 32'(n_mv - b_mv), 0);
        chk("rst_no_cc", 32'(n_cc - b_cc), 0);
        snap();
        start_job(2, 2, 3, 1);
        to(1);
        chk("rst_job_scnt", 32'(S_Count_Fifo), 6);
        to(19);
        chk("rst_job_cc", 32'(Compute_Complete), 1);
        to(50);
        chk("rst_job_rd_total", 32'(n_rd - b_rd), 6);
        chk("rst_job_mv_total", 32'(n_mv - b_mv), 6);
        chk("rst_job_cc_total", 32'(n_cc - b_cc), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
